// File: rtl/vga_display_pipe.sv
// VGA display back-end: raster counters, framebuffer fetch address,
// latency-matched sync/DE/pattern alignment and built-in test patterns.
module vga_display_pipe #(
    parameter int COLOR_BITS    = 4,
    parameter int H_ACTIVE      = 1024,
    parameter int H_FP          = 24,
    parameter int H_SYNC        = 136,
    parameter int H_BP          = 144,
    parameter int V_ACTIVE      = 768,
    parameter int V_FP          = 3,
    parameter int V_SYNC        = 6,
    parameter int V_BP          = 29,
    parameter int H_SYNC_POL    = 0,
    parameter int V_SYNC_POL    = 0,
    parameter int PIXEL_LATENCY = 2,
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW           = $clog2(H_TOTAL),
    localparam int VW           = $clog2(V_TOTAL),
    localparam int CW           = 3 * COLOR_BITS
) (
    input  logic                  clk_75MHz,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [CW-1:0]         solid_color,
    input  logic [CW-1:0]         pixel_data,
    output logic [HW-1:0]         h_pixel,
    output logic [VW-1:0]         v_pixel,
    output logic                  fetch_active,
    output logic                  frame_start,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic [COLOR_BITS-1:0] VGA_R,
    output logic [COLOR_BITS-1:0] VGA_G,
    output logic [COLOR_BITS-1:0] VGA_B,
    output logic                  VGA_DE
);

    typedef enum logic [1:0] {
        MODE_FB    = 2'b00,
        MODE_BARS  = 2'b01,
        MODE_SOLID = 2'b10,
        MODE_GRID  = 2'b11
    } mode_t;

    // One pixel's worth of timing/pattern state travelling alongside the fetch.
    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [HW-1:0] h;
        logic [4:0]    v;
        mode_t         mode;
    } tap_t;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_W  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_W  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          HS_ON    = 1'(H_SYNC_POL);
    localparam logic          VS_ON    = 1'(V_SYNC_POL);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    mode_t         mode_q, mode_eff;
    tap_t          raw, dly;
    logic          hs_q, vs_q, de_q;
    logic [CW-1:0] rgb_q, rgb_d;
    logic [2:0]    bar;
    logic [4:0]    h5;

    assign h_pixel      = h_q;
    assign v_pixel      = v_q;
    assign fetch_active = (h_q < H_ACT_W) && (v_q < V_ACT_W);
    assign frame_start  = en && (h_q == '0) && (v_q == '0);

    // The first pixel of a frame already uses the mode being sampled this cycle.
    assign mode_eff = frame_start ? mode_t'(mode) : mode_q;

    // Raster counter next state: park at (0,0) while disabled.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!en) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end else begin
            h_d = h_q + HW'(1);
        end
    end

    // Raster counter and frame-aligned mode register.
    always_ff @(posedge clk_75MHz) begin
        if (!rst_n) begin
            h_q    <= '0;
            v_q    <= '0;
            mode_q <= MODE_FB;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
            if (frame_start) begin
                mode_q <= mode_t'(mode);
            end
        end
    end

    // Undelayed timing flags; a disabled scan injects an idle pixel.
    always_comb begin
        raw      = '0;
        raw.h    = h_q;
        raw.v    = 5'(v_q);
        raw.mode = mode_eff;
        if (en) begin
            raw.hs = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
            raw.vs = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
            raw.de = fetch_active;
        end
    end

    if (PIXEL_LATENCY == 0) begin : g_no_delay
        assign dly = raw;
    end else begin : g_delay
        tap_t line_q [PIXEL_LATENCY];

        // Shift register matching the framebuffer read latency.
        always_ff @(posedge clk_75MHz) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < unsigned'(PIXEL_LATENCY); i++) begin
                    line_q[i] <= '0;
                end
            end else begin
                line_q[0] <= raw;
                for (int unsigned i = 1; i < unsigned'(PIXEL_LATENCY); i++) begin
                    line_q[i] <= line_q[i-1];
                end
            end
        end

        assign dly = line_q[PIXEL_LATENCY-1];
    end

    assign h5  = 5'(dly.h);
    assign bar = 3'((32'(dly.h) * 32'd8) / 32'(H_ACTIVE));

    // Colour source select; blanked outside the active area.
    always_comb begin
        rgb_d = '0;
        if (dly.de) begin
            case (dly.mode)
                MODE_FB:    rgb_d = pixel_data;
                MODE_BARS:  rgb_d = {{COLOR_BITS{~bar[1]}},
                                     {COLOR_BITS{~bar[2]}},
                                     {COLOR_BITS{~bar[0]}}};
                MODE_SOLID: rgb_d = solid_color;
                MODE_GRID:  rgb_d = ((h5 == '0) || (dly.v == '0)) ? '1 : '0;
                default:    rgb_d = '0;
            endcase
        end
    end

    // Output register driving the VGA pins.
    always_ff @(posedge clk_75MHz) begin
        if (!rst_n) begin
            hs_q  <= ~HS_ON;
            vs_q  <= ~VS_ON;
            de_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= dly.hs ? HS_ON : ~HS_ON;
            vs_q  <= dly.vs ? VS_ON : ~VS_ON;
            de_q  <= dly.de;
            rgb_q <= rgb_d;
        end
    end

    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;
    assign VGA_DE = de_q;
    assign VGA_R  = rgb_q[CW-1 -: COLOR_BITS];
    assign VGA_G  = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign VGA_B  = rgb_q[COLOR_BITS-1:0];

endmodule

// File: tb/tb_vga_display_pipe.sv
// Bench for vga_display_pipe: small-timing instance checked cycle by cycle
// against a frame-position model, plus a default-timing zero-latency instance
// for the mid-line reset case.
module tb_vga_display_pipe;

    localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VSY = 2, VB = 1;
    localparam int HT = HA + HF + HSY + HB;   // 24
    localparam int VT = VA + VF + VSY + VB;   // 12
    localparam int FT = HT * VT;              // 288

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small-timing instance
    logic        rst_n, en;
    logic [1:0]  mode;
    logic [11:0] solid, pix;
    logic [4:0]  hp;
    logic [3:0]  vp;
    logic        fa, fs, hs, vs, de;
    logic [3:0]  r, g, b;

    vga_display_pipe #(
        .COLOR_BITS(4),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .H_SYNC_POL(0), .V_SYNC_POL(0),
        .PIXEL_LATENCY(2)
    ) dut (
        .clk_75MHz(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .solid_color(solid), .pixel_data(pix),
        .h_pixel(hp), .v_pixel(vp), .fetch_active(fa), .frame_start(fs),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_DE(de)
    );

    // Default-timing, zero-latency instance
    logic        rst_b, en_b;
    logic [1:0]  mode_b = 2'b00;
    logic [11:0] solid_b = 12'h000, pix_b = 12'h123;
    logic [10:0] hp_b;
    logic [9:0]  vp_b;
    logic        fa_b, fs_b, hs_b, vs_b, de_b;
    logic [3:0]  r_b, g_b, b_b;

    vga_display_pipe #(
        .PIXEL_LATENCY(0)
    ) dut_b (
        .clk_75MHz(clk), .rst_n(rst_b), .en(en_b), .mode(mode_b),
        .solid_color(solid_b), .pixel_data(pix_b),
        .h_pixel(hp_b), .v_pixel(vp_b), .fetch_active(fa_b), .frame_start(fs_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_DE(de_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Framebuffer content as a function of the fetch address
    function automatic logic [11:0] fb(input int h, input int v);
        return 12'((h * 37 + v * 101 + 5) % 4096);
    endfunction

    logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
    } pin_t;

    function automatic pin_t idle_pins();
        pin_t p;
        p.hs = 1'b1; p.vs = 1'b1; p.de = 1'b0; p.rgb = 12'h000;
        return p;
    endfunction

    // Pin values owed to a pixel at frame position pos under frame mode fm
    function automatic pin_t model_pins(input logic en_i, input int pos,
                                        input logic [1:0] fm, input logic [11:0] sol);
        pin_t p;
        int h, v;
        p = idle_pins();
        h = pos % HT;
        v = pos / HT;
        if (en_i) begin
            p.hs = !(h >= HA + HF && h < HA + HF + HSY);
            p.vs = !(v >= VA + VF && v < VA + VF + VSY);
            p.de = (h < HA) && (v < VA);
            if (p.de) begin
                case (fm)
                    2'b00:   p.rgb = fb(h, v);
                    2'b01:   p.rgb = bar_tab[h * 8 / HA];
                    2'b10:   p.rgb = sol;
                    default: p.rgb = ((h % 32 == 0) || (v % 32 == 0)) ? 12'hFFF : 12'h000;
                endcase
            end
        end
        return p;
    endfunction

    // Model state: linear position in frame, frame mode, pins owed 1..3 cycles ahead
    int         m_pos   = 0;
    logic [1:0] m_mode  = 2'b00;
    bit         m_valid = 1'b0;
    pin_t       q[$];

    // Compare process: mid-cycle, check then advance the model over the next edge
    always @(negedge clk) begin
        pin_t e;
        logic fs_exp;
        if (m_valid) begin
            e = q.pop_front();
            chk("VGA_HS", hs, e.hs);
            chk("VGA_VS", vs, e.vs);
            chk("VGA_DE", de, e.de);
            chk("VGA_RGB", {r, g, b}, e.rgb);
            chk("h_pixel", hp, m_pos % HT);
            chk("v_pixel", vp, m_pos / HT);
            chk("fetch_active", fa, (m_pos % HT < HA) && (m_pos / HT < VA));
            chk("frame_start", fs, en && (m_pos == 0));
        end
        if (!rst_n) begin
            q.delete();
            repeat (3) q.push_back(idle_pins());
            m_pos   = 0;
            m_mode  = 2'b00;
            m_valid = 1'b1;
        end else if (m_valid) begin
            fs_exp = en && (m_pos == 0);
            q.push_back(model_pins(en, m_pos, fs_exp ? mode : m_mode, solid));
            if (fs_exp) m_mode = mode;
            m_pos = en ? (m_pos + 1) % FT : 0;
        end
    end

    // Framebuffer emulation: 2-cycle read latency on the fetch address
    logic [4:0] hm1 = '0, hm2 = '0;
    logic [3:0] vm1 = '0, vm2 = '0;

    task automatic step();
        @(posedge clk);
        #1;
        pix = fb(hm2, vm2);
        hm2 = hm1; vm2 = vm1;
        hm1 = hp;  vm1 = vp;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_fs(input string nm);
        int k = 0;
        do begin
            step();
            k++;
        end while (fs !== 1'b1 && k < 400);
        chk(nm, fs, 1);
    endtask

    task automatic wait_hv(input string nm, input int h, input int v);
        int k = 0;
        do begin
            step();
            k++;
        end while (!(hp == h && vp == v) && k < 400);
        chk(nm, {hp == h, vp == v}, 2'b11);
    endtask

    initial begin
        int k, vs_low, de_cnt;
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; solid = 12'hA5C; pix = '0;
        rst_b = 1'b0; en_b = 1'b0;
        steps(3);

        chk("reset h", hp, 0);
        chk("reset v", vp, 0);
        chk("reset HS", hs, 1);
        chk("reset VS", vs, 1);
        chk("reset DE", de, 0);
        chk("reset RGB", {r, g, b}, 12'h000);
        chk("reset frame_start", fs, 0);
        chk("reset fetch_active", fa, 1);

        // Start scanning in framebuffer mode
        rst_n = 1'b1; en = 1'b1;
        #1;
        chk("first frame_start", fs, 1);
        k = 0;
        while (de !== 1'b1 && k < 20) begin step(); k++; end
        chk("DE latency", k, 3);

        k = 0;
        while (hp !== 5'd0 && k < 40) begin step(); k++; end
        chk("wait h=0", hp, 0);
        k = 0;
        while (hs !== 1'b0 && k < 40) begin step(); k++; end
        chk("HS fall offset", k, 21);
        k = 0;
        while (hs === 1'b0 && k < 40) begin step(); k++; end
        chk("HS width", k, 3);

        wait_fs("frame_start seen");
        k = 0;
        do begin step(); k++; end while (fs !== 1'b1 && k < 400);
        chk("frame period", k, 288);

        vs_low = 0; de_cnt = 0;
        repeat (FT) begin
            step();
            if (vs === 1'b0) vs_low++;
            if (de === 1'b1) de_cnt++;
        end
        chk("VS low cycles", vs_low, 48);
        chk("DE cycles per frame", de_cnt, 128);

        // Colour bars
        mode = 2'b01;
        wait_fs("bars frame");
        steps(3);
        for (int i = 0; i < 16; i++) begin
            if (i == 0)  chk("bar px0", {r, g, b}, 12'hFFF);
            if (i == 3)  chk("bar px3", {r, g, b}, 12'hFF0);
            if (i == 13) chk("bar px13", {r, g, b}, 12'h00F);
            if (i == 15) chk("bar px15", {r, g, b}, 12'h000);
            step();
        end

        // Framebuffer, then solid requested mid-frame at v=4
        mode = 2'b00;
        wait_fs("fb frame");
        wait_hv("reach v=4", 0, 4);
        mode = 2'b10;
        steps(5);
        chk("fb still shown", {r, g, b}, fb(2, 4));
        wait_fs("solid frame");
        steps(3);
        chk("solid first pixel", {r, g, b}, 12'hA5C);
        steps(FT);

        // Grid
        mode = 2'b11;
        wait_fs("grid frame");
        steps(3);
        chk("grid (0,0)", {r, g, b}, 12'hFFF);
        step();
        chk("grid (1,0)", {r, g, b}, 12'hFFF);
        steps(24);
        chk("grid (1,1)", {r, g, b}, 12'h000);

        // Drop enable mid-frame
        mode = 2'b00;
        wait_hv("reach (10,3)", 10, 3);
        en = 1'b0;
        step();
        chk("en drop h", hp, 0);
        chk("en drop v", vp, 0);
        steps(2);
        chk("en drop DE", de, 0);
        chk("en drop RGB", {r, g, b}, 12'h000);
        chk("en drop HS", hs, 1);
        chk("en drop VS", vs, 1);
        steps(5);
        en = 1'b1;
        #1;
        chk("restart frame_start", fs, 1);
        chk("restart h", hp, 0);
        steps(FT + 10);

        // Reset pulse mid-line with scanning enabled
        wait_hv("reach (5,2)", 5, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid reset h", hp, 0);
        chk("mid reset DE", de, 0);
        steps(FT + 10);

        // Default timing, zero latency: one-cycle reset mid-line
        rst_b = 1'b1; en_b = 1'b1;
        steps(40);
        chk("B active DE", de_b, 1);
        chk("B active RGB", {r_b, g_b, b_b}, 12'h123);
        rst_b = 1'b0;
        step();
        chk("B reset HS", hs_b, 1);
        chk("B reset VS", vs_b, 1);
        chk("B reset DE", de_b, 0);
        chk("B reset RGB", {r_b, g_b, b_b}, 12'h000);
        chk("B reset h", hp_b, 0);
        chk("B reset v", vp_b, 0);
        rst_b = 1'b1;
        step();
        chk("B restart DE", de_b, 1);
        chk("B restart RGB", {r_b, g_b, b_b}, 12'h123);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_display_pipe.md
Name: vga_display_pipe

Overview:
Parametrised VGA display back-end combining the timing generator, framebuffer fetch-address output, latency-matched sync/blank alignment and a built-in test-pattern source. It sits between the framebuffer read port and the VGA pins. It generalises the fixed 1024x768@70 Hz display path to arbitrary timing, colour depth, sync polarity and fetch latency.

Parameters:
COLOR_BITS, 4, bits per colour channel
H_ACTIVE / H_FP / H_SYNC / H_BP, 1024 / 24 / 136 / 144, horizontal timing in pixel clocks
V_ACTIVE / V_FP / V_SYNC / V_BP, 768 / 3 / 6 / 29, vertical timing in lines
H_SYNC_POL / V_SYNC_POL, 0 / 0, asserted sync level (0 = active-low)
PIXEL_LATENCY, 2, cycles from h_pixel/v_pixel to matching pixel_data (legal 0..8)
Derived: H_TOTAL = sum of H params; V_TOTAL = sum of V params; HW = clog2(H_TOTAL); VW = clog2(V_TOTAL); CW = 3*COLOR_BITS.

Ports:
clk_75MHz  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
en  in  1  scan enable
mode  in  2  00 framebuffer, 01 colour bars, 10 solid, 11 grid
solid_color  in  CW  {R,G,B} for mode 10
pixel_data  in  CW  {R,G,B} from framebuffer, PIXEL_LATENCY cycles after coordinates
h_pixel  out  HW  current horizontal count (fetch address)
v_pixel  out  VW  current vertical count (fetch address)
fetch_active  out  1  h_pixel < H_ACTIVE and v_pixel < V_ACTIVE
frame_start  out  1  one-cycle pulse when counters are (0,0) and en=1
VGA_HS / VGA_VS  out  1 each  registered syncs
VGA_R / VGA_G / VGA_B  out  COLOR_BITS each  registered colour, 0 outside active area
VGA_DE  out  1  registered active-video flag

Behaviour:
- Reset (rst_n=0 at an edge): h/v counters=0, mode register=00, delay line cleared to inactive. Outputs: VGA_HS=~H_SYNC_POL, VGA_VS=~V_SYNC_POL, RGB=0, VGA_DE=0, frame_start=0. fetch_active is combinational from the counters, so it reads 1 while they sit at (0,0).
- Counter stage: h_pixel increments each cycle while en=1 and wraps H_TOTAL-1 -> 0. v_pixel increments on h wrap and wraps V_TOTAL-1 -> 0.
- en=0: counters synchronously return to (0,0) and hold. The delay line keeps shifting, but inactive values (DE=0, syncs deasserted, RGB=0) are inserted, so the outputs go idle after PIXEL_LATENCY+1 cycles. After en rises, the first counted pixel is (0,0).
- HS asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. VS asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], with vertical transitions aligned to h=0.
- Alignment: raw HS, VS, DE and h_pixel[HW-1:0] / v_pixel[4:0] (for patterns) pass through a PIXEL_LATENCY-deep shift register, then one output register.
- Latency: counter value -> pins = PIXEL_LATENCY+1 cycles, identical for sync, DE and colour. With PIXEL_LATENCY=0, pixel_data is used in the same cycle as the coordinates.
- Mode is sampled into the mode register only when frame_start fires. A change mid-frame takes effect at the next (0,0), so no tearing.
- Mode 00: colour = pixel_data.
- Mode 01: 8 vertical bars, bar index = delayed_h*8/H_ACTIVE (integer). Order: white, yellow, cyan, green, magenta, red, blue, black. "Full" = all-ones channel.
- Mode 10: colour = solid_color.
- Mode 11: white where delayed_h[4:0]==0 or delayed_v[4:0]==0, else black.
- Colour is forced to 0 whenever delayed DE=0, in every mode.
- Simultaneous rst_n=0 and en=1: reset wins.
- Reset mid-frame: next cycle matches the reset values, with no partial-line output.

Test Plan:
- Small timing (H 16/2/3/3 =24, V 8/1/2/1 =12, latency 2), reset then en=1 -> h wraps every 24 cycles; frame_start period 288 cycles; VGA_HS low exactly 3 cycles starting 18+3 cycles after h=0; VGA_VS low exactly 2 lines.
- Mode 00, pixel_data driven as a 2-cycle-delayed function of (h,v) -> VGA_R/G/B equal that function on every DE=1 cycle; zero when DE=0; DE rises exactly 3 cycles after h_pixel=0,v_pixel=0.
- Mode 01 with H_ACTIVE=16 -> per line, pairs of pixels: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- Mode switched 00->10 (solid_color=0xA5C) at mid-frame v=4 -> output unchanged until next frame_start, then every active pixel = 0xA5C.
- en dropped at h=10,v=3 -> counters read (0,0) next cycle; DE=0, RGB=0, syncs deasserted within 3 cycles. en raised -> restart at (0,0).
- rst_n pulsed low for one cycle mid-line, with PIXEL_LATENCY=0 and default parameters -> next cycle: HS=1, VS=1, RGB=0, DE=0, h_pixel=0, v_pixel=0, mode=00.
